// File: rtl/ftm_trace_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ftm_trace_arbiter                                          |
// | Description : Round-robin, burst-bounded arbiter that shares the single  |
// |               Zynq Fabric Trace Module port (32-bit data, 4-bit ATID,    |
// |               valid, clock; no backpressure) between NUM_SRC PL trace    |
// |               sources that each use a valid/ready handshake.             |
// |               Optional macro FTM_TRACE_ARBITER_STATS_EN adds saturating  |
// |               per-source word and stall counters with stat_clear.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ftm_trace_arbiter #(
    parameter int         NUM_SRC   = 4,
    parameter logic [3:0] ATID_BASE = 4'h1,
    parameter int         MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   trace_enable,
    input  logic [NUM_SRC-1:0]     src_enable,
    input  logic [NUM_SRC*32-1:0]  src_data,
    input  logic [NUM_SRC-1:0]     src_valid,
    output logic [NUM_SRC-1:0]     src_ready,
    output logic [31:0]            trace_data,
    output logic [3:0]             trace_atid,
    output logic                   trace_valid,
    output logic                   trace_clock,
    output logic                   busy,
    output logic [2:0]             grant_id
`ifdef FTM_TRACE_ARBITER_STATS_EN
    ,
    input  logic                   stat_clear,
    output logic [NUM_SRC*32-1:0]  stat_words,
    output logic [NUM_SRC*32-1:0]  stat_stall
`endif
);

    // State encoding
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_BURST = 1'b1;

    // Burst counter value of the last word a grant may take
    localparam logic [4:0] c_LAST_CNT = 5'(MAX_BURST - 1);
    localparam logic [2:0] c_LAST_SRC = 3'(NUM_SRC - 1);

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [2:0]          r_rr_ptr;
    logic [4:0]          r_burst_cnt;
    logic [2:0]          r_grant_id;

    logic [NUM_SRC-1:0]  w_elig;
    logic                w_pick_found;
    logic [2:0]          w_pick_idx;

    logic                w_g_valid;
    logic                w_g_en;
    logic [31:0]         w_g_data;
    logic                w_g_ready;
    logic                w_accept;
    logic                w_exit;
    logic [NUM_SRC-1:0]  w_ready;
    logic [2:0]          w_rr_next;

    logic                r_trace_valid;
    logic [31:0]         r_trace_data;
    logic [3:0]          r_trace_atid;

    // (base + off) mod NUM_SRC for base < NUM_SRC and off < NUM_SRC
    function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_SRC) begin
            sum = sum - NUM_SRC;
        end
        return 3'(sum);
    endfunction

    assign w_elig = src_valid & src_enable & {NUM_SRC{trace_enable}};

    // Round-robin pick: first eligible source scanning up from r_rr_ptr
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = 3'd0;
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!w_pick_found && w_elig[i] && (3'(i) == wrap_idx(r_rr_ptr, k))) begin
                    w_pick_found = 1'b1;
                    w_pick_idx   = 3'(i);
                end
            end
        end
    end

    // Select the current grantee's handshake and data lanes
    always_comb begin
        w_g_valid = 1'b0;
        w_g_en    = 1'b0;
        w_g_data  = 32'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_grant_id == 3'(i)) begin
                w_g_valid = src_valid[i];
                w_g_en    = src_enable[i];
                w_g_data  = src_data[32*i +: 32];
            end
        end
    end

    assign w_rr_next = (r_grant_id == c_LAST_SRC) ? 3'd0 : r_grant_id + 3'd1;

    // Next-state, ready and accept decode; ready depends only on state and enables
    always_comb begin
        w_state_nxt = r_state;
        w_g_ready   = 1'b0;
        w_accept    = 1'b0;
        w_exit      = 1'b0;
        w_ready     = '0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = c_ST_BURST;
                end
            end
            c_ST_BURST: begin
                w_g_ready = trace_enable & w_g_en;
                w_accept  = w_g_ready & w_g_valid;
                for (int i = 0; i < NUM_SRC; i++) begin
                    w_ready[i] = (r_grant_id == 3'(i)) & w_g_ready;
                end
                if ((w_accept && (r_burst_cnt == c_LAST_CNT)) ||
                    !w_g_valid || !w_g_en || !trace_enable) begin
                    w_exit      = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant, burst counter and round-robin pointer bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_id  <= 3'd0;
            r_burst_cnt <= 5'd0;
            r_rr_ptr    <= 3'd0;
        end else if (r_state == c_ST_IDLE) begin
            if (w_pick_found) begin
                r_grant_id  <= w_pick_idx;
                r_burst_cnt <= 5'd0;
            end
        end else begin
            if (w_accept) begin
                r_burst_cnt <= r_burst_cnt + 5'd1;
            end
            if (w_exit) begin
                r_rr_ptr <= w_rr_next;
            end
        end
    end

    // Trace port register: an accepted word appears exactly one cycle later, else zeros
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trace_valid <= 1'b0;
            r_trace_data  <= 32'd0;
            r_trace_atid  <= 4'd0;
        end else begin
            r_trace_valid <= w_accept;
            r_trace_data  <= w_accept ? w_g_data : 32'd0;
            r_trace_atid  <= w_accept ? (ATID_BASE + {1'b0, r_grant_id}) : 4'd0;
        end
    end

    assign src_ready   = w_ready;
    assign trace_valid = r_trace_valid;
    assign trace_data  = r_trace_data;
    assign trace_atid  = r_trace_atid;
    assign trace_clock = clk;
    assign busy        = (r_state == c_ST_BURST);
    assign grant_id    = r_grant_id;

`ifdef FTM_TRACE_ARBITER_STATS_EN
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_stats
            logic [31:0] r_words;
            logic [31:0] r_stall;

            // Saturating accepted-word and stall counters; clear beats increment
            always_ff @(posedge clk) begin
                if (rst || stat_clear) begin
                    r_words <= 32'd0;
                    r_stall <= 32'd0;
                end else begin
                    if (src_valid[gi] && w_ready[gi] && (r_words != 32'hFFFF_FFFF)) begin
                        r_words <= r_words + 32'd1;
                    end
                    if (src_valid[gi] && !w_ready[gi] && (r_stall != 32'hFFFF_FFFF)) begin
                        r_stall <= r_stall + 32'd1;
                    end
                end
            end

            assign stat_words[32*gi +: 32] = r_words;
            assign stat_stall[32*gi +: 32] = r_stall;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_ftm_trace_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ftm_trace_arbiter                                       |
// | Description : Directed self-checking bench for ftm_trace_arbiter with    |
// |               hand-computed expected trace-port sequences.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ftm_trace_arbiter;

    logic         clk;
    logic         rst;
    logic         trace_enable;
    logic [3:0]   src_enable;
    logic [127:0] src_data;
    logic [3:0]   src_valid;
    logic [3:0]   src_ready;
    logic [31:0]  trace_data;
    logic [3:0]   trace_atid;
    logic         trace_valid;
    logic         trace_clock;
    logic         busy;
    logic [2:0]   grant_id;
`ifdef FTM_TRACE_ARBITER_STATS_EN
    logic         stat_clear;
    logic [127:0] stat_words;
    logic [127:0] stat_stall;
`endif

    int          nvec;
    int          nerr;
    int          cnt  [4];
    int          lim  [4];
    logic [31:0] base [4];

    ftm_trace_arbiter #(
        .NUM_SRC   (4),
        .ATID_BASE (4'h1),
        .MAX_BURST (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .trace_enable (trace_enable),
        .src_enable   (src_enable),
        .src_data     (src_data),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .trace_data   (trace_data),
        .trace_atid   (trace_atid),
        .trace_valid  (trace_valid),
        .trace_clock  (trace_clock),
        .busy         (busy),
        .grant_id     (grant_id)
`ifdef FTM_TRACE_ARBITER_STATS_EN
        ,
        .stat_clear   (stat_clear),
        .stat_words   (stat_words),
        .stat_stall   (stat_stall)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive each source's valid/data from its word counter and limit
    task automatic apply();
        for (int i = 0; i < 4; i++) begin
            src_valid[i]          = (cnt[i] < lim[i]);
            src_data[32*i +: 32]  = base[i] + 32'(cnt[i]);
        end
        #1;
    endtask

    // Clock one edge; sources advance on valid&ready seen before the edge
    task automatic step();
        logic [3:0] acc;
        acc = src_valid & src_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) cnt[i]++;
        end
    endtask

    task automatic cyc();
        apply();
        step();
    endtask

    task automatic reset_dut();
        for (int i = 0; i < 4; i++) begin
            lim[i] = 0;
            cnt[i] = 0;
        end
        src_valid = 4'h0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [13:0] pat;
        int          k;
        int          b;
        int          w;
        int          s;
        logic [31:0] d;

        nvec = 0;
        nerr = 0;
        rst = 1'b1;
        trace_enable = 1'b1;
        src_enable = 4'hF;
        src_valid = 4'h0;
        src_data = '0;
`ifdef FTM_TRACE_ARBITER_STATS_EN
        stat_clear = 1'b0;
`endif
        for (int i = 0; i < 4; i++) begin
            cnt[i]  = 0;
            lim[i]  = 100;
            base[i] = 32'h1000 * 32'(i);
        end

        // Reset held two cycles with every source valid
        for (int r = 0; r < 2; r++) begin
            cyc();
            check("rst_valid", 64'(trace_valid), 64'd0);
            check("rst_ready", 64'(src_ready), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
        end
        rst = 1'b0;
        apply();
        check("idle_ready", 64'(src_ready), 64'd0);
        check("trace_clock", 64'(trace_clock), 64'(clk));
        step();
        check("first_busy", 64'(busy), 64'd1);
        check("first_grant", 64'(grant_id), 64'd0);
        check("first_ready", 64'(src_ready), 64'h1);
        check("first_valid", 64'(trace_valid), 64'd0);

        // Reset mid-burst discards the word accepted in that cycle
        rst = 1'b1;
        apply();
        step();
        check("midrst_valid", 64'(trace_valid), 64'd0);
        check("midrst_data", 64'(trace_data), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        rst = 1'b0;

        // Single stream from src2: 4 on, gap, 4 on, gap, 2 on
        reset_dut();
        lim[2]  = 10;
        base[2] = 32'hA0;
        pat = 14'b01101111011110;
        k = 0;
        for (int j = 0; j < 14; j++) begin
            cyc();
            check("ss_valid", 64'(trace_valid), 64'(pat[j]));
            if (pat[j]) begin
                check("ss_data", 64'(trace_data), 64'(32'hA0 + 32'(k)));
                check("ss_atid", 64'(trace_atid), 64'h3);
                k++;
            end else begin
                check("ss_data0", 64'(trace_data), 64'd0);
                check("ss_atid0", 64'(trace_atid), 64'd0);
            end
        end
        check("ss_count", 64'(cnt[2]), 64'd10);

        // Round robin across four always-valid sources
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            lim[i]  = 100;
            base[i] = 32'h1000 * 32'(i);
        end
        for (int j = 0; j < 25; j++) begin
            cyc();
            if ((j % 5) == 0) begin
                check("rr_gap", 64'(trace_valid), 64'd0);
            end else begin
                b = j / 5;
                w = (j % 5) - 1;
                s = b % 4;
                d = 32'(32'h1000 * s + (b / 4) * 4 + w);
                check("rr_valid", 64'(trace_valid), 64'd1);
                check("rr_atid", 64'(trace_atid), 64'(1 + s));
                check("rr_data", 64'(trace_data), 64'(d));
            end
        end

        // Early exit of src1 after two words; next pointer is src2 so src3 wins over src0
        reset_dut();
        lim[1] = 2;   base[1] = 32'hB0;
        lim[3] = 100; base[3] = 32'hD0;
        base[0] = 32'hC0;
        cyc();
        check("ee_grant1", 64'(grant_id), 64'd1);
        check("ee_busy1", 64'(busy), 64'd1);
        cyc();
        check("ee_w0", 64'({trace_valid, trace_atid, trace_data}), 64'({1'b1, 4'h2, 32'hB0}));
        cyc();
        check("ee_w1", 64'({trace_valid, trace_atid, trace_data}), 64'({1'b1, 4'h2, 32'hB1}));
        lim[0] = 100;
        cyc();
        check("ee_gap_valid", 64'(trace_valid), 64'd0);
        check("ee_gap_busy", 64'(busy), 64'd0);
        check("ee_gap_grant", 64'(grant_id), 64'd1);
        cyc();
        check("ee_grant3", 64'(grant_id), 64'd3);
        check("ee_busy3", 64'(busy), 64'd1);
        cyc();
        check("ee_w3", 64'({trace_valid, trace_atid, trace_data}), 64'({1'b1, 4'h4, 32'hD0}));

        // trace_enable drops after the second accept
        reset_dut();
        lim[0]  = 100;
        base[0] = 32'h50;
        cyc();
        cyc();
        check("dis_w0", 64'(trace_data), 64'h50);
        cyc();
        check("dis_w1", 64'(trace_data), 64'h51);
        trace_enable = 1'b0;
        apply();
        check("dis_ready", 64'(src_ready), 64'd0);
        check("dis_busy_same", 64'(busy), 64'd1);
        step();
        check("dis_valid", 64'(trace_valid), 64'd0);
        check("dis_busy", 64'(busy), 64'd0);
        for (int j = 0; j < 3; j++) begin
            cyc();
            check("dis_hold_busy", 64'(busy), 64'd0);
            check("dis_hold_valid", 64'(trace_valid), 64'd0);
        end
        check("dis_count", 64'(cnt[0]), 64'd2);
        trace_enable = 1'b1;
        cyc();
        check("dis_regrant", 64'(busy), 64'd1);
        cyc();
        check("dis_w2", 64'({trace_valid, trace_atid, trace_data}), 64'({1'b1, 4'h1, 32'h52}));

`ifdef FTM_TRACE_ARBITER_STATS_EN
        // Five words from src0 with three blocked cycles, then a clear
        reset_dut();
        lim[0]  = 5;
        base[0] = 32'h70;
        trace_enable = 1'b0;
        cyc();
        trace_enable = 1'b1;
        for (int j = 0; j < 10; j++) begin
            cyc();
        end
        check("st_words0", 64'(stat_words[31:0]), 64'd5);
        check("st_stall0", 64'(stat_stall[31:0]), 64'd3);
        check("st_words1", 64'(stat_words[63:32]), 64'd0);
        lim[0] = 6;
        stat_clear = 1'b1;
        cyc();
        stat_clear = 1'b0;
        check("st_clr_words", 64'(stat_words[31:0]), 64'd0);
        check("st_clr_stall", 64'(stat_stall[31:0]), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ftm_trace_arbiter.md
Name: ftm_trace_arbiter

Overview:
Shares the single Zynq Fabric Trace Module trace port (32-bit data, 4-bit ATID, valid, clock; no backpressure) between NUM_SRC PL trace sources. Each source gets a fixed ATID and sends 32-bit words over a valid/ready handshake. Sources are served round-robin in bounded bursts. Registered outputs drive the FTM trace-port signals in the FPGA-side direction.

Parameters:
NUM_SRC, 4, number of trace sources (2..8)
ATID_BASE, 4'h1, ATID of source 0; source i uses (ATID_BASE + i) mod 16
MAX_BURST, 4, max words accepted from one source per grant (1..16)

Ports:
clk  in  1  single clock; also forwarded to trace_clock
rst  in  1  synchronous, active-high reset
trace_enable  in  1  global enable; 0 = no new grants, current burst closes
src_enable  in  NUM_SRC  per-source enable mask
src_data  in  NUM_SRC*32  source i word at bits [32*i+31:32*i]
src_valid  in  NUM_SRC  source i word available
src_ready  out  NUM_SRC  source i word accepted this cycle when valid&ready
trace_data  out  32  FTM trace DATA
trace_atid  out  4  FTM trace ATID
trace_valid  out  1  FTM trace VALID
trace_clock  out  1  FTM trace CLOCK, direct assignment of clk (no logic)
busy  out  1  high in BURST state
grant_id  out  3  index of currently/last granted source

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, rr_ptr=0, burst_cnt=0, grant_id=0; trace_valid=0, trace_data=0, trace_atid=0, src_ready=0, busy=0.
- Eligible(i) = src_valid[i] & src_enable[i] & trace_enable.
- IDLE: if any source is eligible, pick the first eligible index scanning rr_ptr, rr_ptr+1, ... (mod NUM_SRC). Register grant_id, clear burst_cnt, go to BURST. Otherwise stay in IDLE. src_ready = 0 in IDLE.
- BURST: src_ready[grant_id] = trace_enable & src_enable[grant_id]. All other ready bits are 0.
- src_ready never depends on src_valid (combinational from registered state plus enables only).
- Accept (valid&ready on grantee): next cycle trace_valid=1, trace_data=word, trace_atid=ATID(grant_id). Latency is exactly 1 cycle. burst_cnt increments.
- In a cycle with no accept, next-cycle trace_valid=0, and trace_data/trace_atid are driven to 0.
- BURST -> IDLE when any of the following holds; rr_ptr <= (grant_id+1) mod NUM_SRC:
  - an accept with burst_cnt==MAX_BURST-1;
  - grantee src_valid=0;
  - grantee src_enable=0;
  - trace_enable=0.
- The word accepted in the exit cycle is still emitted.
- Throughput: one grantee streaming continuously yields MAX_BURST words per MAX_BURST+1 cycles (one IDLE arbitration bubble).
- A single eligible source is re-granted after the bubble, so it is never starved.
- Starvation bound: a continuously valid, enabled source waits at most (NUM_SRC-1)*(MAX_BURST+1) cycles for a grant.
- Disable mid-burst: ready drops in the same cycle, no word is lost, and already-accepted words are still emitted.
- Reset mid-burst: takes effect at the next edge. trace_valid=0 on the following cycle and any pending output word is discarded.
- busy = (state==BURST). grant_id holds its value in IDLE.

Optional Feature:
Macro FTM_TRACE_ARBITER_STATS_EN.
- When defined, adds per-source counters (flattened, 32 bits per source), both reset to 0 and both saturating at 32'hFFFFFFFF:
  - stat_words  out  NUM_SRC*32: count of accepted words.
  - stat_stall  out  NUM_SRC*32: count of cycles with src_valid=1 & src_ready=0.
- Adds input stat_clear (1 bit). stat_clear is a synchronous clear; if clear and increment occur in the same cycle, clear wins.
- When not defined, these ports and counters do not exist, and arbitration behaviour is identical.

Test Plan:
- Reset: rst high 2 cycles with all src_valid=1 -> trace_valid=0, src_ready=0, busy=0 throughout; first grant goes to src0 in the cycle after the rst release edge.
- Single stream: MAX_BURST=4, src2 sends 0xA0..0xA9 continuously -> trace_data in order with atid=4'h3. Pattern is 4 valid cycles, 1 gap, 4 valid cycles, 1 gap, 2 valid cycles. No words lost.
- Round-robin: src0..src3 all valid, each word = 0x1000*i+n -> bursts of 4 in source order 0,1,2,3,0; atids 1,2,3,4,1.
- Early exit: src1 valid for 2 words then drops, src3 waiting -> 2 words with atid 2, bubble, then src3 granted; rr_ptr=2 after src1's exit.
- Disable mid-burst: trace_enable falls after the 2nd accept -> src_ready low in the same cycle, exactly 2 words output, busy=0 next cycle, no further grants until trace_enable=1.
- Stats (FTM_TRACE_ARBITER_STATS_EN): src0 sends 5 words while blocked 3 cycles -> stat_words[0]=5, stat_stall[0]=3; stat_clear pulse -> both 0.
